// File: rtl/ppcm_arbiter_pkg.sv
// ppcm_arbiter_pkg: shared state encodings, port indices and width helper for the PCM arbiter
package ppcm_arbiter_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_e;
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
    function automatic int get_width(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) if ((v >> i) != 0) w = i + 1;
        return w;
    endfunction
endpackage

// File: rtl/ppcm_arbiter_if.sv
// ppcm_arbiter_if: one requester port of the PCM arbiter (request side drives cs/addr/burst)
interface ppcm_arbiter_if #(parameter int AW = 22) ();
    logic          cs;
    logic [AW-1:0] addr;
    logic          burst;
    logic [31:0]   dout;
    logic          busy;
    logic          ack;
    logic          err;
    modport master (output cs, addr, burst, input dout, busy, ack, err);
    modport slave  (input cs, addr, burst, output dout, busy, ack, err);
endinterface

// File: rtl/ppcm_arbiter_pick.sv
// ppcm_arbiter_pick: picks the winning port of two requests; round-robin ties under PPCM_ARB_RR_EN, else port 0 wins
module ppcm_arbiter_pick
    import ppcm_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
`ifdef PPCM_ARB_RR_EN
    input  logic       last_i,
`endif
    output logic       pick_o
);
    // a lone requester always wins; only ties depend on the configuration
    always_comb begin
`ifdef PPCM_ARB_RR_EN
        pick_o = (&req_i) ? ~last_i : (req_i[0] ? P0 : P1);
`else
        pick_o = req_i[0] ? P0 : P1;
`endif
    end
endmodule

// File: rtl/ppcm_arbiter.sv
// ppcm_arbiter: shares one read-only PCM core between two requesters; PPCM_ARB_RR_EN selects round-robin ties
module ppcm_arbiter
    import ppcm_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ppcm_arbiter_if.slave        m0_io,
    ppcm_arbiter_if.slave        m1_io,
    output logic                 core_cs_o,
    output logic [ADDR_BITS-3:0] core_addr_o,
    output logic                 core_burst_o,
    input  logic [31:0]          core_dout_i,
    input  logic                 core_busy_i,
    input  logic                 core_ack_i
);
    localparam int WW = get_width(TIMEOUT - 1);

    state_e               state_q;
    logic                 owner_q;
    logic                 owner_d;
    logic [WW-1:0]        wdog_q;
    logic                 core_cs_q;
    logic [ADDR_BITS-3:0] core_addr_q;
    logic                 core_burst_q;
    logic                 own_cs;
    logic [ADDR_BITS-3:0] own_addr;
    logic                 own_burst;
    logic                 done;
    logic                 hung;
`ifdef PPCM_ARB_RR_EN
    logic                 last_q;
`endif

    ppcm_arbiter_pick u_pick (
        .req_i  ({m1_io.cs, m0_io.cs}),
`ifdef PPCM_ARB_RR_EN
        .last_i (last_q),
`endif
        .pick_o (owner_d)
    );

    // owner's request fields, final-word completion and watchdog expiry
    always_comb begin
        own_cs    = owner_q ? m1_io.cs    : m0_io.cs;
        own_addr  = owner_q ? m1_io.addr  : m0_io.addr;
        own_burst = owner_q ? m1_io.burst : m0_io.burst;
        done      = state_q == S_XFER && core_ack_i && !core_busy_i;
        hung      = state_q == S_XFER && !core_ack_i && wdog_q == WW'(TIMEOUT - 1);
    end

    // grant FSM with registered core-side outputs, so mX_cs never reaches core_cs combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= P0;
            wdog_q       <= '0;
            core_cs_q    <= 1'b0;
            core_addr_q  <= '0;
            core_burst_q <= 1'b0;
`ifdef PPCM_ARB_RR_EN
            last_q       <= P1;
`endif
        end else if (state_q == S_IDLE) begin
            if (!core_busy_i && (m0_io.cs || m1_io.cs)) begin
                state_q      <= S_XFER;
                owner_q      <= owner_d;
                wdog_q       <= '0;
                core_cs_q    <= 1'b1;
                core_addr_q  <= owner_d ? m1_io.addr  : m0_io.addr;
                core_burst_q <= owner_d ? m1_io.burst : m0_io.burst;
`ifdef PPCM_ARB_RR_EN
                last_q       <= owner_d;
`endif
            end
        end else if (done || hung) begin
            state_q      <= S_IDLE;
            core_cs_q    <= 1'b0;
            core_addr_q  <= '0;
            core_burst_q <= 1'b0;
        end else begin
            wdog_q       <= core_ack_i ? '0 : wdog_q + 1'b1;
            core_cs_q    <= own_cs;
            core_addr_q  <= own_addr;
            core_burst_q <= own_burst;
        end
    end

    assign core_cs_o    = core_cs_q;
    assign core_addr_o  = core_addr_q;
    assign core_burst_o = core_burst_q;

    assign m0_io.dout = core_dout_i;
    assign m1_io.dout = core_dout_i;
    assign m0_io.ack  = core_ack_i && state_q == S_XFER && owner_q == P0;
    assign m1_io.ack  = core_ack_i && state_q == S_XFER && owner_q == P1;
    assign m0_io.busy = m0_io.cs && !(done && owner_q == P0);
    assign m1_io.busy = m1_io.cs && !(done && owner_q == P1);
    assign m0_io.err  = hung && owner_q == P0;
    assign m1_io.err  = hung && owner_q == P1;
endmodule

// File: tb/tb_ppcm_arbiter.sv
// tb_ppcm_arbiter: directed scenarios plus random stimulus against a transaction-level arbiter model
module tb_ppcm_arbiter;
    localparam int AB = 24;
    localparam int AW = AB - 2;
    localparam int TO = 16;
`ifdef PPCM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_cs;
    logic [AW-1:0] core_addr;
    logic          core_burst;
    logic [31:0]   core_dout;
    logic          core_busy;
    logic          core_ack;
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    ppcm_arbiter_if #(.AW(AW)) m0 ();
    ppcm_arbiter_if #(.AW(AW)) m1 ();

    ppcm_arbiter #(.ADDR_BITS(AB), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_io        (m0),
        .m1_io        (m1),
        .core_cs_o    (core_cs),
        .core_addr_o  (core_addr),
        .core_burst_o (core_burst),
        .core_dout_i  (core_dout),
        .core_busy_i  (core_busy),
        .core_ack_i   (core_ack)
    );

    // reference model: who holds the core, how long since the last ack, what the core sees
    bit            md_xfer = 1'b0;
    int            md_owner = 0;
    int            md_last = 1;
    int            md_cnt = 0;
    int            mw;
    bit            ex_cs = 1'b0;
    logic [AW-1:0] ex_addr = '0;
    bit            ex_burst = 1'b0;

    function automatic int winner(input bit r0, input bit r1, input int last);
        if (r0 && r1) return RR ? 1 - last : 0;
        return r0 ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            md_xfer = 0; md_owner = 0; md_last = 1; md_cnt = 0;
            ex_cs = 0; ex_addr = '0; ex_burst = 0;
        end else if (!md_xfer) begin
            if (!core_busy && (m0.cs || m1.cs)) begin
                mw = winner(m0.cs, m1.cs, md_last);
                md_owner = mw; md_last = mw; md_cnt = 0; md_xfer = 1;
                ex_cs = 1; ex_addr = mw == 1 ? m1.addr : m0.addr; ex_burst = mw == 1 ? m1.burst : m0.burst;
            end
        end else if ((core_ack && !core_busy) || (!core_ack && md_cnt == TO - 1)) begin
            md_xfer = 0; ex_cs = 0; ex_addr = '0; ex_burst = 0;
        end else begin
            md_cnt = core_ack ? 0 : md_cnt + 1;
            ex_cs = md_owner == 1 ? m1.cs : m0.cs;
            ex_addr = md_owner == 1 ? m1.addr : m0.addr;
            ex_burst = md_owner == 1 ? m1.burst : m0.burst;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit fin;
        bit hang;
        fin  = md_xfer && core_ack && !core_busy;
        hang = md_xfer && !core_ack && md_cnt == TO - 1;
        check("core_cs", core_cs, ex_cs);
        check("core_addr", core_addr, ex_addr);
        check("core_burst", core_burst, ex_burst);
        check("m0_dout", m0.dout, core_dout);
        check("m1_dout", m1.dout, core_dout);
        check("m0_ack", m0.ack, core_ack && md_xfer && md_owner == 0);
        check("m1_ack", m1.ack, core_ack && md_xfer && md_owner == 1);
        check("m0_busy", m0.busy, m0.cs && !(fin && md_owner == 0));
        check("m1_busy", m1.busy, m1.cs && !(fin && md_owner == 1));
        check("m0_err", m0.err, hang && md_owner == 0);
        check("m1_err", m1.err, hang && md_owner == 1);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        settle();
        @(negedge clk);
    endtask

    initial begin
        int n1;
        int bad;
        int got[4];
        m0.cs = 0; m0.addr = '0; m0.burst = 0;
        m1.cs = 1; m1.addr = '0; m1.burst = 0;
        core_dout = '0; core_busy = 0; core_ack = 0; rst_n = 0;
        @(negedge clk);
        settle();
        check("rst_core_cs", core_cs, 0);
        check("rst_m1_busy", m1.busy, 1);
        check("rst_m0_busy", m0.busy, 0);
        @(negedge clk);
        m1.cs = 0; rst_n = 1;

        m0.cs = 1; m0.addr = 22'h1234;
        tick();
        settle();
        check("rd_cs", core_cs, 1);
        check("rd_addr", core_addr, 22'h1234);
        @(negedge clk);
        core_busy = 1;
        tick();
        core_busy = 0; core_ack = 1; core_dout = 32'hDEADBEEF;
        settle();
        check("rd_ack", m0.ack, 1);
        check("rd_dout", m0.dout, 32'hDEADBEEF);
        check("rd_m1_ack", m1.ack, 0);
        check("rd_busy_rel", m0.busy, 0);
        @(negedge clk);
        m0.cs = 0; core_ack = 0;
        settle();
        check("rd_idle", core_cs, 0);
        @(negedge clk);

        m1.cs = 1; m1.addr = 22'h10; m1.burst = 1;
        tick();
        m0.cs = 1; m0.addr = 22'h2222;
        n1 = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            core_busy = i != 7;
            core_ack = i % 2 == 1;
            core_dout = $urandom;
            settle();
            n1 += int'(m1.ack);
            if (m0.ack || !m0.busy || !core_cs || core_addr != 22'h10) bad++;
            @(negedge clk);
        end
        check("bu_acks", n1, 4);
        check("bu_hold_stall", bad, 0);
        m1.cs = 0; m1.burst = 0; core_ack = 0; core_busy = 0;
        tick();
        core_busy = 1;
        tick();
        core_busy = 0; core_ack = 1;
        settle();
        check("bu_m0_after", m0.ack, 1);
        @(negedge clk);
        m0.cs = 0; core_ack = 0;
        tick();

        m1.cs = 1; m1.addr = 22'h30; m1.burst = 1;
        tick();
        core_busy = 1;
        tick();
        core_ack = 1;
        tick();
        core_ack = 0; rst_n = 0;
        tick();
        rst_n = 1; core_ack = 1;
        settle();
        check("mr_cs", core_cs, 0);
        check("mr_ack", m1.ack, 0);
        @(negedge clk);
        core_ack = 0; core_busy = 0; m0.cs = 1; m0.addr = 22'h40;
        tick();
        settle();
        check("mr_first", core_addr, 22'h40);
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            core_busy = 1;
            tick();
            core_busy = 0; core_ack = 1; core_dout = $urandom;
            settle();
            got[t] = m0.ack ? 0 : (m1.ack ? 1 : 9);
            @(negedge clk);
            core_ack = 0;
            tick();
        end
        for (int t = 0; t < 4; t++) check($sformatf("tie%0d", t), got[t], RR ? t % 2 : 0);

        rst_n = 0; m0.cs = 0; m1.cs = 0; m1.burst = 0; core_busy = 1;
        tick();
        rst_n = 1; m0.cs = 1; m0.addr = 22'h55;
        bad = 0;
        repeat (100) begin
            settle();
            if (core_cs) bad++;
            @(negedge clk);
        end
        check("init_block", bad, 0);
        core_busy = 0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            core_busy = k > 1;
            settle();
            if (k == 1) check("init_cs", core_cs, 1);
            check($sformatf("wd_err%0d", k), m0.err, k == 16);
            @(negedge clk);
        end
        core_ack = 1;
        settle();
        check("wd_cs_low", core_cs, 0);
        check("wd_late_ack", m0.ack, 0);
        check("wd_err_once", m0.err, 0);
        @(negedge clk);
        core_ack = 0; core_busy = 0; m0.cs = 0;
        tick();

        repeat (3000) begin
            rst_n = $urandom_range(0, 299) != 0;
            m0.cs = $urandom_range(0, 2) != 0;
            m1.cs = $urandom_range(0, 2) != 0;
            m0.addr = AW'($urandom);
            m1.addr = AW'($urandom);
            m0.burst = 1'($urandom);
            m1.burst = 1'($urandom);
            core_busy = 1'($urandom);
            core_ack = $urandom_range(0, 7) == 0;
            core_dout = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
